// File: rtl/time_keypad_entry_if.sv
// Keypad-to-time-entry bus: raw keys and entry controls in, accepted digit and BCD time register out.
interface time_keypad_entry_if;
  logic [9:0]  keys;
  logic        load_en;
  logic        clear_entry;
  logic [3:0]  digit;
  logic        digit_valid;
  logic        key_error;
  logic [15:0] time_bcd;
  logic [2:0]  entry_count;

  modport master (
    output keys, load_en, clear_entry,
    input  digit, digit_valid, key_error, time_bcd, entry_count
  );

  modport slave (
    input  keys, load_en, clear_entry,
    output digit, digit_valid, key_error, time_bcd, entry_count
  );
endinterface

// File: rtl/time_keypad_entry.sv
// Debounced one-hot digit keypad front end: emits one strobe per press and shifts
// accepted digits into a 4-digit MM:SS BCD register for the downstream timer.
module time_keypad_entry #(
  parameter int DEBOUNCE = 4
) (
  input logic                 clock,
  input logic                 clear,
  time_keypad_entry_if.slave  kp
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_PRESSED,
    S_RELEASE
  } state_t;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_ONE,
    CLS_MULTI
  } cls_t;

  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE);
  localparam logic [2:0] MAX_DIGITS = 3'd4;

  function automatic cls_t classify(input logic [9:0] k);
    int n;
    n = 0;
    for (int i = 0; i < 10; i++) n += int'(k[i]);
    if (n == 0) return CLS_NONE;
    if (n == 1) return CLS_ONE;
    return CLS_MULTI;
  endfunction

  function automatic logic [3:0] encode(input logic [9:0] k);
    logic [3:0] code;
    code = '0;
    for (int i = 0; i < 10; i++) begin
      if (k[i]) code = 4'(i);
    end
    return code;
  endfunction

  // Stable-sample counter saturates rather than wrapping back below the threshold.
  function automatic logic [3:0] cnt_inc(input logic [3:0] c);
    if (c == 4'hF) return c;
    return c + 4'd1;
  endfunction

  state_t      state;
  logic [3:0]  cnt;
  logic [3:0]  latched;
  logic [3:0]  digit_q;
  logic        digit_valid_q;
  logic        key_error_q;
  logic [15:0] time_bcd_q;
  logic [2:0]  entry_count_q;

  cls_t        cls_p0;
  logic [3:0]  code_p0;
  logic [3:0]  cnt_nxt_p0;
  logic        accept_p0;

  // Stage p0: classify the raw key lines and decide whether this edge accepts a digit.
  always_comb begin
    cls_p0     = classify(kp.keys);
    code_p0    = encode(kp.keys);
    cnt_nxt_p0 = cnt_inc(cnt);
    accept_p0  = (state == S_DEBOUNCE) && (cls_p0 == CLS_ONE) &&
                 (code_p0 == latched) && (cnt_nxt_p0 == DB_LAST);
  end

  // Registered FSM, strobes and BCD entry register.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state         <= S_IDLE;
      cnt           <= '0;
      latched       <= '0;
      digit_q       <= '0;
      digit_valid_q <= 1'b0;
      key_error_q   <= 1'b0;
      time_bcd_q    <= '0;
      entry_count_q <= '0;
    end else begin
      digit_valid_q <= 1'b0;
      key_error_q   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cls_p0 == CLS_ONE) begin
            state   <= S_DEBOUNCE;
            latched <= code_p0;
            cnt     <= 4'd1;
          end else if (cls_p0 == CLS_MULTI) begin
            key_error_q <= 1'b1;
          end
        end

        S_DEBOUNCE: begin
          if (cls_p0 == CLS_ONE) begin
            if (code_p0 != latched) begin
              latched <= code_p0;
              cnt     <= 4'd1;
            end else if (accept_p0) begin
              state         <= S_PRESSED;
              cnt           <= '0;
              digit_q       <= latched;
              digit_valid_q <= 1'b1;
            end else begin
              cnt <= cnt_nxt_p0;
            end
          end else begin
            state       <= S_IDLE;
            cnt         <= '0;
            key_error_q <= (cls_p0 == CLS_MULTI);
          end
        end

        // Held keys, including extra ones, are ignored until a clean release.
        S_PRESSED: begin
          if (cls_p0 == CLS_NONE) begin
            state <= S_RELEASE;
            cnt   <= 4'd1;
          end
        end

        S_RELEASE: begin
          if (cls_p0 == CLS_NONE) begin
            if (cnt_nxt_p0 == DB_LAST) begin
              state <= S_IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt_nxt_p0;
            end
          end else begin
            state <= S_PRESSED;
            cnt   <= '0;
          end
        end

        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase

      // A clear on the accept edge wins; that digit is lost.
      if (kp.clear_entry) begin
        time_bcd_q    <= '0;
        entry_count_q <= '0;
      end else if (accept_p0 && kp.load_en && (entry_count_q < MAX_DIGITS)) begin
        time_bcd_q    <= {time_bcd_q[11:0], latched};
        entry_count_q <= entry_count_q + 3'd1;
      end
    end
  end

  assign kp.digit       = digit_q;
  assign kp.digit_valid = digit_valid_q;
  assign kp.key_error   = key_error_q;
  assign kp.time_bcd    = time_bcd_q;
  assign kp.entry_count = entry_count_q;

endmodule

// File: tb/tb_time_keypad_entry.sv
// Scoreboard bench for time_keypad_entry: directed key sequences push expected strobes,
// a negedge monitor pops and compares whenever a strobe appears.
module tb_time_keypad_entry;
  localparam int DEBOUNCE = 4;

  logic clock;
  logic clear;
  int   cyc;
  int   checks;
  int   errors;

  time_keypad_entry_if kp ();

  time_keypad_entry #(.DEBOUNCE(DEBOUNCE)) dut (
    .clock (clock),
    .clear (clear),
    .kp    (kp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic        is_err;
    logic [3:0]  digit;
    logic [15:0] tbcd;
    logic [2:0]  cnt;
    int          at;
  } ev_t;

  ev_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input logic err, input logic [3:0] d, input logic [15:0] t,
                           input logic [2:0] c, input int at);
    ev_t e;
    e.is_err = err;
    e.digit  = d;
    e.tbcd   = t;
    e.cnt    = c;
    e.at     = at;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [9:0] k, input int n);
    kp.keys = k;
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input int k, input logic [15:0] t, input logic [2:0] c);
    expect_ev(1'b0, 4'(k), t, c, cyc + DEBOUNCE);
    drive(10'(1) << k, 5);
    drive('0, 5);
  endtask

  // Monitor: every strobe must match the head of the scoreboard, including its cycle.
  always @(negedge clock) begin
    ev_t e;
    if (clear === 1'b1 && (kp.digit_valid === 1'b1 || kp.key_error === 1'b1)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event actual dv=%0b err=%0b digit=%0h required none (cycle %0d)",
                 kp.digit_valid, kp.key_error, kp.digit, cyc);
      end else begin
        e = sb.pop_front();
        check("digit_valid", 32'(kp.digit_valid), 32'(!e.is_err));
        check("key_error", 32'(kp.key_error), 32'(e.is_err));
        check("event_cycle", cyc, e.at);
        check("digit", 32'(kp.digit), 32'(e.digit));
        check("time_bcd", 32'(kp.time_bcd), 32'(e.tbcd));
        check("entry_count", 32'(kp.entry_count), 32'(e.cnt));
      end
    end
  end

  localparam logic [9:0] B1 = 10'b00_0000_0010;
  localparam logic [9:0] B2 = 10'b00_0000_0100;
  localparam logic [9:0] B3 = 10'b00_0000_1000;
  localparam logic [9:0] B4 = 10'b00_0001_0000;
  localparam logic [9:0] B5 = 10'b00_0010_0000;
  localparam logic [9:0] B7 = 10'b00_1000_0000;
  localparam logic [9:0] B8 = 10'b01_0000_0000;

  initial begin
    logic press_pat [7];
    logic rel_pat [7];
    int   c;
    checks = 0;
    errors = 0;
    press_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    rel_pat   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    clear          = 1'b0;
    kp.keys        = '0;
    kp.load_en     = 1'b0;
    kp.clear_entry = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_digit", 32'(kp.digit), 0);
    check("rst_digit_valid", 32'(kp.digit_valid), 0);
    check("rst_key_error", 32'(kp.key_error), 0);
    check("rst_time_bcd", 32'(kp.time_bcd), 0);
    check("rst_entry_count", 32'(kp.entry_count), 0);
    clear = 1'b1;
    @(negedge clock);

    // Single clean press of 7.
    kp.load_en = 1'b1;
    press(7, 16'h0007, 3'd1);

    // Reset mid-debounce clears everything; strobe follows DEBOUNCE edges after release.
    kp.load_en = 1'b0;
    drive(B3, 2);
    clear = 1'b0;
    #1;
    check("midrst_digit", 32'(kp.digit), 0);
    check("midrst_digit_valid", 32'(kp.digit_valid), 0);
    check("midrst_key_error", 32'(kp.key_error), 0);
    check("midrst_time_bcd", 32'(kp.time_bcd), 0);
    check("midrst_entry_count", 32'(kp.entry_count), 0);
    @(negedge clock);
    clear = 1'b1;
    expect_ev(1'b0, 4'd3, 16'h0000, 3'd0, cyc + DEBOUNCE);
    drive(B3, 6);
    drive('0, 5);

    // Press and release bounce on key 2.
    kp.load_en = 1'b1;
    c = cyc;
    expect_ev(1'b0, 4'd2, 16'h0002, 3'd1, c + 7);
    for (int i = 0; i < 7; i++) drive(press_pat[i] ? B2 : 10'b0, 1);
    for (int i = 0; i < 7; i++) drive(rel_pat[i] ? B2 : 10'b0, 1);
    drive('0, 2);

    kp.clear_entry = 1'b1;
    @(negedge clock);
    kp.clear_entry = 1'b0;
    check("clr_time_bcd", 32'(kp.time_bcd), 0);
    check("clr_entry_count", 32'(kp.entry_count), 0);

    // Four digits fill the register; the fifth is strobed but dropped.
    press(1, 16'h0001, 3'd1);
    press(2, 16'h0012, 3'd2);
    press(3, 16'h0123, 3'd3);
    press(0, 16'h1230, 3'd4);
    press(9, 16'h1230, 3'd4);

    // Two keys from idle: error pulse only.
    expect_ev(1'b1, 4'd9, 16'h1230, 3'd4, cyc + 1);
    drive(B4 | B5, 1);
    drive('0, 3);

    // Extra key during a held press is ignored.
    expect_ev(1'b0, 4'd4, 16'h1230, 3'd4, cyc + DEBOUNCE);
    drive(B4, 5);
    drive(B4 | B5, 3);
    drive('0, 5);

    // Clear on the strobe edge of 8 wins over the shift.
    expect_ev(1'b0, 4'd8, 16'h0000, 3'd0, cyc + DEBOUNCE);
    drive(B8, 3);
    kp.clear_entry = 1'b1;
    drive(B8, 1);
    kp.clear_entry = 1'b0;
    drive(B8, 1);
    drive('0, 5);

    kp.load_en = 1'b0;
    press(5, 16'h0000, 3'd0);
    kp.load_en = 1'b1;
    press(6, 16'h0006, 3'd1);

    // Switching keys mid-debounce restarts the count on the new key.
    expect_ev(1'b0, 4'd2, 16'h0062, 3'd2, cyc + 2 + DEBOUNCE);
    drive(B1, 2);
    drive(B2, 6);
    drive('0, 5);

    // A second key during debounce aborts with an error.
    expect_ev(1'b1, 4'd2, 16'h0062, 3'd2, cyc + 3);
    drive(B1, 2);
    drive(B1 | B3, 1);
    drive('0, 3);

    drive('0, 5);
    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
